grf_wb_queue: RTL and testbench

- Write-side front end for the general register file (GRF).
- Merges two writeback sources onto the GRF's single write port (A3/WD/WE):
  - the pipeline W stage, which is never stalled and always has priority;
  - the multi-cycle multiply/divide unit (MDU) result path, which uses a valid/ready handshake.
- MDU results are buffered in a small FIFO and drained into idle write-port cycles.
- Exposes pending-write lookups so the hazard unit can stall readers of registers still in the queue.

---
 rtl/grf_wb_queue_pkg.sv | 17 +
 rtl/wbq_fifo.sv | 81 ++++++++
 rtl/grf_wb_queue.sv | 93 +++++++++
 tb/tb_grf_wb_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_queue_pkg.sv
// Shared MIPS-wide definitions for the GRF writeback queue.
package grf_wb_queue_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // One queued MDU result; live=0 marks an entry superseded by a younger pipeline write.
  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Circular buffer of MDU results with per-entry kill and register lookup.
module wbq_fifo
  import grf_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wbq_entry_t       push_entry,
  input  logic             pop,
  input  logic             kill,
  input  logic [REG_W-1:0] kill_a3,
  input  logic [REG_W-1:0] look_a1,
  input  logic [REG_W-1:0] look_a2,
  output wbq_entry_t       head_c,
  output logic [DEPTH-1:0] match1_c,
  output logic [DEPTH-1:0] match2_c,
  output logic [PTR_W:0]   count,
  output logic             full_c
);

  localparam int unsigned CNT_W = PTR_W + 1;

  wbq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] off [DEPTH];
  logic [DEPTH-1:0] occ;

  // Occupancy per slot (distance from head below count) and lookup matches.
  always_comb begin
    occ      = '0;
    match1_c = '0;
    match2_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]      = PTR_W'(i) - head;
      occ[i]      = {1'b0, off[i]} < count;
      match1_c[i] = occ[i] && mem[i].live && (mem[i].a3 == look_a1) && (look_a1 != REG_ZERO);
      match2_c[i] = occ[i] && mem[i].live && (mem[i].a3 == look_a2) && (look_a2 != REG_ZERO);
    end
  end

  assign head_c = mem[head];
  assign full_c = (count == CNT_W'(DEPTH));

  // Storage, pointers and occupancy count; a push into the tail overrides any kill on that slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (occ[i] && (mem[i].a3 == kill_a3)) begin
            mem[i].live <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[head].live <= 1'b0;
        head           <= head + PTR_W'(1);
      end
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// Merges the W-stage and queued MDU results onto the single GRF write port.
module grf_wb_queue
  import grf_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic [DATA_W-1:0] pipe_pc,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_a3,
  input  logic [DATA_W-1:0] mdu_wd,
  input  logic [DATA_W-1:0] mdu_pc,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc,
  input  logic [REG_W-1:0]  q_a1,
  input  logic [REG_W-1:0]  q_a2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [PTR_W:0]    count
);

  logic             pipe_wr;
  logic             full;
  logic             fifo_push;
  logic             fifo_pop;
  wbq_entry_t       push_entry;
  wbq_entry_t       head;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  // Writes to $0 are dropped; a same-cycle MDU result to the same register is enqueued dead.
  assign pipe_wr              = pipe_we && (pipe_a3 != REG_ZERO);
  assign mdu_ready            = !full;
  assign fifo_push            = mdu_valid && !full && (mdu_a3 != REG_ZERO);
  assign fifo_pop             = !pipe_wr && (count != '0);
  assign push_entry.live      = !(pipe_wr && (pipe_a3 == mdu_a3));
  assign push_entry.a3        = mdu_a3;
  assign push_entry.wd        = mdu_wd;
  assign push_entry.pc        = mdu_pc;
  assign q_hit1               = |match1;
  assign q_hit2               = |match2;

  wbq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill       (pipe_wr),
    .kill_a3    (pipe_a3),
    .look_a1    (q_a1),
    .look_a2    (q_a2),
    .head_c     (head),
    .match1_c   (match1),
    .match2_c   (match2),
    .count      (count),
    .full_c     (full)
  );

  // Write-port arbitration: pipeline first, then the queue head; held off while in reset.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = REG_ZERO;
    grf_wd = '0;
    grf_pc = '0;
    if (pipe_wr) begin
      grf_we = 1'b1;
      grf_a3 = pipe_a3;
      grf_wd = pipe_wd;
      grf_pc = pipe_pc;
    end else if (count != '0) begin
      grf_we = head.live;
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
    if (!reset) begin
      grf_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: inputs change on the falling edge, outputs checked 1 ns later.
module tb_grf_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd;
  logic [31:0] mdu_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_hit1;
  logic        q_hit2;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grf_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .pipe_a3   (pipe_a3),
    .pipe_wd   (pipe_wd),
    .pipe_pc   (pipe_pc),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_a3    (mdu_a3),
    .mdu_wd    (mdu_wd),
    .mdu_pc    (mdu_pc),
    .grf_we    (grf_we),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .grf_pc    (grf_pc),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic mv, input logic [4:0] ma3, input logic [31:0] mwd);
    @(negedge clk);
    pipe_we   = pwe;
    pipe_a3   = pa3;
    pipe_wd   = pwd;
    pipe_pc   = 32'h4000_0000 | pwd;
    mdu_valid = mv;
    mdu_a3    = ma3;
    mdu_wd    = mwd;
    mdu_pc    = 32'h100 + 32'(ma3);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    q_a1  = 5'd0;
    q_a2  = 5'd0;
    pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0; pipe_pc = '0;
    mdu_valid = 1'b0; mdu_a3 = '0; mdu_wd = '0; mdu_pc = '0;

    // Reset holds grf_we low even with a pipeline write present.
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    chk("rst_we_gated", 32'(grf_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    idle();
    chk("idle_we", 32'(grf_we), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_ready", 32'(mdu_ready), 32'd1);

    // Single MDU push, drained the following cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
    chk("push_we", 32'(grf_we), 32'd0);
    chk("push_count", 32'(count), 32'd0);
    q_a1 = 5'd8;
    idle();
    chk("drain_count", 32'(count), 32'd1);
    chk("drain_we", 32'(grf_we), 32'd1);
    chk("drain_a3", 32'(grf_a3), 32'd8);
    chk("drain_wd", grf_wd, 32'h1234);
    chk("drain_pc", grf_pc, 32'h108);
    chk("drain_hit", 32'(q_hit1), 32'd1);
    idle();
    chk("after_drain_count", 32'(count), 32'd0);
    chk("after_drain_we", 32'(grf_we), 32'd0);
    chk("after_drain_hit", 32'(q_hit1), 32'd0);
    q_a1 = 5'd0;

    // Fill the queue while the pipeline owns the port.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(1 + i), 32'h100 * 32'(i + 1));
      chk("fill_pipe_a3", 32'(grf_a3), 32'(10 + i));
      chk("fill_pipe_wd", grf_wd, 32'hA0 + 32'(i));
      chk("fill_ready", 32'(mdu_ready), 32'd1);
      chk("fill_count", 32'(count), 32'(i));
    end
    // Full: no push even though the head pops this cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h500);
    chk("full_ready", 32'(mdu_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_drain_a3", 32'(grf_a3), 32'd1);
    chk("full_drain_wd", grf_wd, 32'h100);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h500);
    chk("refill_ready", 32'(mdu_ready), 32'd1);
    chk("refill_count", 32'(count), 32'd3);
    chk("refill_drain_a3", 32'(grf_a3), 32'd2);
    idle();
    chk("order3_count", 32'(count), 32'd3);
    chk("order3_a3", 32'(grf_a3), 32'd3);
    chk("order3_wd", grf_wd, 32'h300);
    idle();
    chk("order4_a3", 32'(grf_a3), 32'd4);
    chk("order4_we", 32'(grf_we), 32'd1);
    idle();
    chk("order5_a3", 32'(grf_a3), 32'd5);
    chk("order5_wd", grf_wd, 32'h500);
    chk("order5_count", 32'(count), 32'd1);
    idle();
    chk("order_empty_count", 32'(count), 32'd0);
    chk("order_empty_we", 32'(grf_we), 32'd0);

    // Streaming push+pop every cycle drives both pointers through several wraps.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(16 + i), 32'hC000 + 32'(i));
      chk("stream_we", 32'(grf_we), 32'(i > 0));
      chk("stream_count", 32'(count), 32'(i > 0));
      if (i > 0) begin
        chk("stream_a3", 32'(grf_a3), 32'(16 + i - 1));
        chk("stream_wd", grf_wd, 32'hC000 + 32'(i - 1));
      end
    end
    idle();
    chk("stream_last_a3", 32'(grf_a3), 32'd23);
    chk("stream_last_wd", grf_wd, 32'hC007);
    idle();
    chk("stream_empty", 32'(count), 32'd0);

    // WAW kill of a queued entry by a younger pipeline write.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA);
    q_a1 = 5'd5;
    q_a2 = 5'd5;
    drive(1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd0, 32'h0);
    chk("kill_pipe_wd", grf_wd, 32'hBBBB);
    chk("kill_pipe_pc", grf_pc, 32'h4000_BBBB);
    chk("kill_hit1_before", 32'(q_hit1), 32'd1);
    chk("kill_hit2_before", 32'(q_hit2), 32'd1);
    q_a2 = 5'd0;
    idle();
    chk("kill_hit1_after", 32'(q_hit1), 32'd0);
    chk("kill_hit2_zero", 32'(q_hit2), 32'd0);
    chk("kill_dead_count", 32'(count), 32'd1);
    chk("kill_dead_we", 32'(grf_we), 32'd0);
    idle();
    chk("kill_popped", 32'(count), 32'd0);
    q_a1 = 5'd0;

    // Same-cycle MDU and pipeline writes to r7: pipeline wins, entry enqueued dead.
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'hDEAD);
    chk("same_we", 32'(grf_we), 32'd1);
    chk("same_a3", 32'(grf_a3), 32'd7);
    chk("same_wd", grf_wd, 32'h77);
    chk("same_ready", 32'(mdu_ready), 32'd1);
    q_a1 = 5'd7;
    idle();
    chk("same_count", 32'(count), 32'd1);
    chk("same_dead_we", 32'(grf_we), 32'd0);
    chk("same_dead_hit", 32'(q_hit1), 32'd0);
    q_a1 = 5'd0;
    idle();
    chk("same_popped", 32'(count), 32'd0);

    // MDU result to $0 completes the handshake but enqueues nothing.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
    chk("zero_ready", 32'(mdu_ready), 32'd1);
    idle();
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_we", 32'(grf_we), 32'd0);

    // Pipeline write to $0 is not a write.
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    chk("pipe_r0_we", 32'(grf_we), 32'd0);

    // Reset asserted mid-drain discards the queue at once.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd10, 32'hE0, 1'b1, 5'(1 + i), 32'h10 * 32'(i + 1));
    end
    idle();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_a3", 32'(grf_a3), 32'd1);
    chk("pre_rst_we", 32'(grf_we), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_we", 32'(grf_we), 32'd0);
    drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
    chk("hold_rst_we", 32'(grf_we), 32'd0);
    reset = 1'b1;
    idle();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_we", 32'(grf_we), 32'd0);
    chk("post_rst_ready", 32'(mdu_ready), 32'd1);
    idle();
    chk("post_rst_we2", 32'(grf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
